// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: latches one request, resolves it through the external
// comparator, then issues a held PC redirect followed by a counted flush.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic            br_jal,
  input  logic            br_jalr,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  output logic [XLEN-1:0] cmp_rs1,
  output logic [XLEN-1:0] cmp_rs2,
  output logic            cmp_unsign,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            done,
  output logic            taken,
  output logic            exc_misalign,
  output logic            exc_illegal,
  output logic [31:0]     cnt_br,
  output logic [31:0]     cnt_tk
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RESOLVE  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [1:0]      state_reg;
  logic [2:0]      f3_reg;
  logic            jal_reg;
  logic            jalr_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] imm_reg;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic            unsign_reg;
  logic            redir_valid_reg;
  logic [XLEN-1:0] redir_pc_reg;
  logic            flush_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic            done_reg;
  logic            taken_reg;
  logic            exc_misalign_reg;
  logic            exc_illegal_reg;
  logic [31:0]     cnt_br_reg;
  logic [31:0]     cnt_tk_reg;

  logic            cond_hit;
  logic            is_jump;
  logic            f3_illegal;
  logic            illegal_c;
  logic            take_c;
  logic            misalign_c;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_c;

  // Comparator result decode; BLT/BGE/BLTU/BGEU share lt, inverted by funct3[0].
  always_comb begin
    cond_hit = 1'b0;
    case (f3_reg)
      3'b000:                      cond_hit = cmp_eq;
      3'b001:                      cond_hit = !cmp_eq;
      3'b100, 3'b101,
      3'b110, 3'b111:              cond_hit = cmp_lt ^ f3_reg[0];
      default:                     cond_hit = 1'b0;
    endcase
  end

  assign is_jump    = jal_reg | jalr_reg;
  assign f3_illegal = (f3_reg[2:1] == 2'b01);
  assign illegal_c  = !is_jump && f3_illegal;
  assign take_c     = is_jump || (cond_hit && !f3_illegal);
  assign jalr_sum   = rs1_reg + imm_reg;
  assign target_c   = jalr_reg ? (jalr_sum & ALIGN_MASK) : (pc_reg + imm_reg);
  assign misalign_c = take_c && (target_c[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      f3_reg           <= '0;
      jal_reg          <= 1'b0;
      jalr_reg         <= 1'b0;
      pc_reg           <= '0;
      imm_reg          <= '0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      unsign_reg       <= 1'b0;
      redir_valid_reg  <= 1'b0;
      redir_pc_reg     <= '0;
      flush_reg        <= 1'b0;
      flush_cnt_reg    <= '0;
      done_reg         <= 1'b0;
      taken_reg        <= 1'b0;
      exc_misalign_reg <= 1'b0;
      exc_illegal_reg  <= 1'b0;
      cnt_br_reg       <= '0;
      cnt_tk_reg       <= '0;
    end else begin
      done_reg         <= 1'b0;
      taken_reg        <= 1'b0;
      exc_misalign_reg <= 1'b0;
      exc_illegal_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (br_valid) begin
            f3_reg     <= br_funct3;
            jal_reg    <= br_jal;
            jalr_reg   <= br_jalr;
            pc_reg     <= br_pc;
            imm_reg    <= br_imm;
            rs1_reg    <= br_rs1;
            rs2_reg    <= br_rs2;
            unsign_reg <= br_funct3[1];
            state_reg  <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          exc_illegal_reg <= illegal_c;
          if (!take_c || misalign_c) begin
            // Misaligned taken targets resolve as not-taken with no redirect.
            exc_misalign_reg <= misalign_c;
            done_reg         <= 1'b1;
            cnt_br_reg       <= cnt_br_reg + 32'd1;
            state_reg        <= ST_IDLE;
          end else begin
            redir_pc_reg    <= target_c;
            redir_valid_reg <= 1'b1;
            state_reg       <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (redir_ready) begin
            redir_valid_reg <= 1'b0;
            done_reg        <= 1'b1;
            taken_reg       <= 1'b1;
            flush_reg       <= 1'b1;
            flush_cnt_reg   <= FLUSH_LAST;
            cnt_br_reg      <= cnt_br_reg + 32'd1;
            cnt_tk_reg      <= cnt_tk_reg + 32'd1;
            state_reg       <= ST_FLUSH;
          end
        end
        default: begin
          if (flush_cnt_reg == '0) begin
            flush_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign br_ready     = (state_reg == ST_IDLE);
  assign cmp_rs1      = rs1_reg;
  assign cmp_rs2      = rs2_reg;
  assign cmp_unsign   = unsign_reg;
  assign redir_valid  = redir_valid_reg;
  assign redir_pc     = redir_pc_reg;
  assign flush        = flush_reg;
  assign done         = done_reg;
  assign taken        = taken_reg;
  assign exc_misalign = exc_misalign_reg;
  assign exc_illegal  = exc_illegal_reg;
  assign cnt_br       = cnt_br_reg;
  assign cnt_tk       = cnt_tk_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stimulus pushes model results, a monitor
// pops and compares them whenever the DUT reports done or a redirect.
module tb_branch_ctrl;
  localparam int XLEN = 32;
  localparam int FLUSH_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            br_valid = 1'b0;
  logic            br_ready;
  logic [2:0]      br_funct3 = '0;
  logic            br_jal = 1'b0;
  logic            br_jalr = 1'b0;
  logic [XLEN-1:0] br_pc = '0, br_imm = '0, br_rs1 = '0, br_rs2 = '0;
  logic [XLEN-1:0] cmp_rs1, cmp_rs2;
  logic            cmp_unsign, cmp_eq, cmp_lt;
  logic            redir_valid;
  logic            redir_ready = 1'b1;
  logic [XLEN-1:0] redir_pc;
  logic            flush, done, taken, exc_misalign, exc_illegal;
  logic [31:0]     cnt_br, cnt_tk;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_jal(br_jal), .br_jalr(br_jalr), .br_pc(br_pc),
    .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2), .cmp_rs1(cmp_rs1),
    .cmp_rs2(cmp_rs2), .cmp_unsign(cmp_unsign), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .done(done), .taken(taken), .exc_misalign(exc_misalign),
    .exc_illegal(exc_illegal), .cnt_br(cnt_br), .cnt_tk(cnt_tk)
  );

  // Comparator attached to the DUT
  assign cmp_eq = (cmp_rs1 == cmp_rs2);
  assign cmp_lt = cmp_unsign ? (cmp_rs1 < cmp_rs2) : ($signed(cmp_rs1) < $signed(cmp_rs2));

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic        mis;
    logic        ill;
    logic [31:0] tgt;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt_br = '0;
  logic [31:0] exp_cnt_tk = '0;
  bit          mon_en = 1'b0;
  int          rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: branch rules evaluated directly on the request fields
  function automatic exp_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    logic c;
    logic [31:0] tgt;
    e.ill = 1'b0;
    case (f3)
      3'd0: c = (rs1 == rs2);
      3'd1: c = (rs1 != rs2);
      3'd4: c = ($signed(rs1) <  $signed(rs2));
      3'd5: c = ($signed(rs1) >= $signed(rs2));
      3'd6: c = (rs1 <  rs2);
      3'd7: c = (rs1 >= rs2);
      default: begin c = 1'b0; e.ill = 1'b1; end
    endcase
    if (jal || jalr) begin
      c = 1'b1;
      e.ill = 1'b0;
    end
    tgt = jalr ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    e.mis = c && ((tgt % 4) != 0);
    e.tk  = c && !e.mis;
    e.tgt = tgt;
    e.acc = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       redir_ready = 1'b1;
      1:       redir_ready = ($urandom_range(0, 2) != 0);
      default: redir_ready = 1'b0;
    endcase
  end

  // Monitor
  initial begin
    int   wait_k;
    int   flush_run;
    exp_t e;
    wait_k = 0;
    flush_run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        wait_k = 0;
        flush_run = 0;
      end else begin
        if (redir_valid) begin
          chk("br_ready_in_redirect", br_ready, 1'b0);
          chk("redir_has_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            chk("redir_expected", exp_q[0].tk, 1'b1);
            chk("redir_pc", redir_pc, exp_q[0].tgt);
          end
          if (!redir_ready) wait_k++;
        end
        if (flush) begin
          flush_run++;
          chk("br_ready_in_flush", br_ready, 1'b0);
        end else if (flush_run != 0) begin
          chk("flush_len", flush_run, FLUSH_CYCLES);
          flush_run = 0;
        end
        if (done) begin
          chk("done_has_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            exp_cnt_br = exp_cnt_br + 32'd1;
            if (e.tk) exp_cnt_tk = exp_cnt_tk + 32'd1;
            chk("taken", taken, e.tk);
            chk("exc_misalign", exc_misalign, e.mis);
            chk("exc_illegal", exc_illegal, e.ill);
            chk("flush_at_done", flush, e.tk);
            chk("cnt_br", cnt_br, exp_cnt_br);
            chk("cnt_tk", cnt_tk, exp_cnt_tk);
            chk("latency", cyc - e.acc, e.tk ? (3 + wait_k) : 2);
            $display("branch tgt=%08h taken=%0b mis=%0b ill=%0b cnt_br=%0d", e.tgt, taken,
                     exc_misalign, exc_illegal, cnt_br);
          end
          wait_k = 0;
        end else begin
          chk("pulse_without_done", {taken, exc_misalign, exc_illegal}, 3'b000);
        end
      end
    end
  end

  task automatic send(input logic [2:0] f3, input logic jal, input logic jalr,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] rs2, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    br_valid = 1'b1; br_funct3 = f3; br_jal = jal; br_jalr = jalr;
    br_pc = pc; br_imm = imm; br_rs1 = rs1; br_rs2 = rs2;
    n = 0;
    while (!br_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!br_ready) begin
      chk("accept_timeout", br_ready, 1'b1);
      br_valid = 1'b0;
    end else begin
      e = model(f3, jal, jalr, pc, imm, rs1, rs2);
      e.acc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      br_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !br_ready || flush) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_redir();
    int n;
    n = 0;
    while (!redir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("redir_valid_seen", redir_valid, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          a0, a1, kind;
    logic [2:0]  f3;
    logic        jl, jr;
    logic [31:0] pc, imm, rs1, rs2;

    repeat (3) @(negedge clk);
    chk("rst_br_ready", br_ready, 1'b1);
    chk("rst_redir_valid", redir_valid, 1'b0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk("rst_outputs", {flush, done, taken, exc_misalign, exc_illegal}, 5'b0);
    chk("rst_cmp", {cmp_rs1, cmp_rs2, 31'h0, cmp_unsign}, 64'h0);
    chk("rst_counters", {cnt_br, cnt_tk}, 64'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    rr_mode = 0;
    send(3'b000, 0, 0, 32'h100, 32'h20, 32'h1234, 32'h1234, a0);
    drain();
    send(3'b110, 0, 0, 32'h200, 32'h40, 32'hFFFFF230, 32'hFFFFF234, a0);
    send(3'b100, 0, 0, 32'h200, 32'h40, 32'hFFFF1234, 32'h00001230, a0);
    send(3'b111, 0, 0, 32'h200, 32'h40, 32'hFFFF1234, 32'h00001230, a0);
    send(3'b101, 0, 0, 32'h200, 32'h40, 32'hFFFF1234, 32'h00001230, a0);
    drain();

    // JALR with the redirect held off for several cycles
    rr_mode = 2;
    send(3'b000, 0, 1, 32'h400, 32'h3, 32'h1001, 32'h0, a0);
    wait_redir();
    repeat (5) begin
      @(negedge clk);
      chk("hold_redir_valid", redir_valid, 1'b1);
      chk("hold_redir_pc", redir_pc, 32'h1004);
      chk("hold_br_ready", br_ready, 1'b0);
    end
    rr_mode = 0;
    drain();

    send(3'b000, 1, 0, 32'h100, 32'h2, 32'h0, 32'h0, a0);
    send(3'b010, 0, 0, 32'h100, 32'h8, 32'h5, 32'h5, a0);
    send(3'b011, 0, 0, 32'h100, 32'h8, 32'h5, 32'h6, a0);
    send(3'b000, 1, 0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, a0);
    send(3'b000, 1, 1, 32'h100, 32'h10, 32'h2000, 32'h0, a0);
    drain();

    // Back-to-back accepts with br_valid kept asserted
    send(3'b001, 0, 0, 32'h300, 32'h10, 32'h55, 32'h55, a0);
    send(3'b001, 0, 0, 32'h300, 32'h10, 32'h77, 32'h77, a1);
    chk("b2b_gap_not_taken", a1 - a0, 2);
    send(3'b000, 0, 0, 32'h300, 32'h10, 32'h9, 32'h9, a0);
    send(3'b000, 0, 0, 32'h500, 32'h20, 32'h9, 32'h9, a1);
    chk("b2b_gap_taken", a1 - a0, 3 + FLUSH_CYCLES);
    drain();

    // Counter wrap: preload cnt_br to all ones
    @(negedge clk);
    force dut.cnt_br_reg = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_br_reg;
    exp_cnt_br = 32'hFFFFFFFF;
    @(negedge clk);
    chk("cnt_br_preload", cnt_br, 32'hFFFFFFFF);
    send(3'b001, 0, 0, 32'h100, 32'h10, 32'h3, 32'h3, a0);
    drain();
    chk("cnt_br_wrapped", cnt_br, 32'h0);

    // Reset while a redirect is pending
    send(3'b000, 0, 0, 32'h100, 32'h10, 32'h1, 32'h1, a0);
    drain();
    rr_mode = 2;
    send(3'b000, 0, 0, 32'h600, 32'h40, 32'h4, 32'h4, a0);
    wait_redir();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_redir_valid", redir_valid, 1'b0);
    chk("midrst_flush", flush, 1'b0);
    chk("midrst_br_ready", br_ready, 1'b1);
    chk("midrst_cnt_tk", cnt_tk, 32'h0);
    exp_q.delete();
    exp_cnt_br = '0;
    exp_cnt_tk = '0;
    rr_mode = 0;
    rst_n = 1'b1;
    send(3'b001, 0, 0, 32'h100, 32'h10, 32'h1, 32'h2, a0);
    drain();

    for (int i = 0; i < 300; i++) begin
      f3   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      jl   = (kind == 0) || (kind == 2);
      jr   = (kind == 1) || (kind == 2);
      rs1  = $urandom;
      rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      if ($urandom_range(0, 5) == 0) rs2 = rs1 ^ 32'h80000000;
      pc   = $urandom & 32'hFFFFFFFC;
      imm  = $urandom;
      if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFFFFFC;
      rr_mode = ((i % 50) < 25) ? 1 : 0;
      send(f3, jl, jr, pc, imm, rs1, rs2, a0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rr_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
